tcounter_param: RTL and testbench



---
 rtl/tcounter_pkg.sv | 19 +
 rtl/tcounter_param_if.sv | 35 +++
 rtl/tcounter_tff.sv | 25 ++
 rtl/tcounter_param.sv | 108 ++++++++++
 tb/tb_tcounter_param.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/tcounter_pkg.sv
// tcounter_pkg: shared constants and helpers for the tcounter_param counter.
//   TC_DIR_UP / TC_DIR_DOWN : encodings of the 'up' direction input.
//   tc_clamp_load()         : clamps a parallel-load value into 0..modulus-1.
package tcounter_pkg;

  localparam logic TC_DIR_UP   = 1'b1;
  localparam logic TC_DIR_DOWN = 1'b0;

  // Values at or above the modulus would leave the counter outside its range,
  // so they are pinned to the top count instead.
  function automatic logic [31:0] tc_clamp_load(input logic [31:0] val,
                                                input int unsigned modulus);
    if (val >= modulus) begin
      return modulus - 32'd1;
    end
    return val;
  endfunction

endpackage

// File: rtl/tcounter_param_if.sv
// tcounter_param_if: control/status bundle of the tcounter_param counter.
//   clear    : synchronous active-high clear
//   en       : count enable
//   up       : direction (TC_DIR_UP / TC_DIR_DOWN)
//   load     : synchronous parallel-load strobe
//   load_val : value to load (clamped to MODULUS-1)
//   q        : registered count
//   tc       : combinational terminal count
//   wrap     : registered one-cycle wrap pulse
// Modports: master drives the controls, slave is the counter.
interface tcounter_param_if #(
  parameter int unsigned WIDTH = 4
);
  import tcounter_pkg::*;

  logic             clear;
  logic             en;
  logic             up;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             wrap;

  modport master (
    output clear, en, up, load, load_val,
    input  q, tc, wrap
  );

  modport slave (
    input  clear, en, up, load, load_val,
    output q, tc, wrap
  );

endinterface

// File: rtl/tcounter_tff.sv
// tcounter_tff: one-bit T flip-flop cell used as a counter bit.
//   clk     : clock, state changes on rising edge
//   clear_n : asynchronous active-low clear
//   clear   : synchronous active-high clear (wins over t)
//   t       : toggle enable
//   q       : registered bit value
module tcounter_tff (
  input  logic clk,
  input  logic clear_n,
  input  logic clear,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      q <= 1'b0;
    end else if (clear) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/tcounter_param.sv
// tcounter_param: parametrised up/down modulo counter built from T-flop bits.
//   WIDTH   : counter width in bits (1..31)
//   MODULUS : count range 0..MODULUS-1, legal 2..2**WIDTH
//   clk     : clock
//   clear_n : asynchronous active-low reset (q=0, wrap=0)
//   bus     : tcounter_param_if.slave (clear, en, up, load, load_val, q, tc, wrap)
// Edge priority: clear > load > en > hold.
// Build option: define TCOUNTER_SAT_EN for saturating mode (holds at the ends,
// wrap tied to 0). Without it the counter wraps modulo MODULUS.
module tcounter_param
  import tcounter_pkg::*;
#(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned MODULUS = 2 ** WIDTH
) (
  input  logic           clk,
  input  logic           clear_n,
  tcounter_param_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 31) begin : gen_bad_width
    $error("tcounter_param: WIDTH must be in 1..31");
  end
  if (MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : gen_bad_modulus
    $error("tcounter_param: MODULUS must be in 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] q_w;
  logic [WIDTH-1:0] next_val;
  logic [WIDTH-1:0] load_clamped;
  logic [WIDTH-1:0] t_w;
  logic             at_max;
  logic             at_zero;
  logic             dir_up;

  assign dir_up       = (bus.up == TC_DIR_UP);
  assign at_max       = (q_w == MaxVal);
  assign at_zero      = (q_w == '0);
  assign load_clamped = WIDTH'(tc_clamp_load(32'(bus.load_val), MODULUS));

  // Next value ignoring clear; the bit cells apply clear themselves.
  always_comb begin
    next_val = q_w;
    if (bus.load) begin
      next_val = load_clamped;
    end else if (bus.en) begin
      if (dir_up) begin
`ifdef TCOUNTER_SAT_EN
        next_val = at_max ? q_w : q_w + WIDTH'(1);
`else
        next_val = at_max ? '0 : q_w + WIDTH'(1);
`endif
      end else begin
`ifdef TCOUNTER_SAT_EN
        next_val = at_zero ? q_w : q_w - WIDTH'(1);
`else
        next_val = at_zero ? MaxVal : q_w - WIDTH'(1);
`endif
      end
    end
  end

  // Each bit toggles exactly where it differs from the selected next value.
  assign t_w = q_w ^ next_val;

  for (genvar i = 0; i < WIDTH; i++) begin : gen_bit
    tcounter_tff u_tff (
      .clk     (clk),
      .clear_n (clear_n),
      .clear   (bus.clear),
      .t       (t_w[i]),
      .q       (q_w[i])
    );
  end

  assign bus.q  = q_w;
  assign bus.tc = bus.en & ((dir_up & at_max) | (~dir_up & at_zero));

`ifdef TCOUNTER_SAT_EN
  assign bus.wrap = 1'b0;
`else
  logic wrap_d;
  logic wrap_q;

  // A wrap happens only on a counting edge that leaves the end of the range.
  always_comb begin
    wrap_d = 1'b0;
    if (!bus.load && bus.en) begin
      wrap_d = dir_up ? at_max : at_zero;
    end
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      wrap_q <= 1'b0;
    end else if (bus.clear) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= wrap_d;
    end
  end

  assign bus.wrap = wrap_q;
`endif

endmodule

// File: tb/tb_tcounter_param.sv
// tb_tcounter_param: directed bench for tcounter_param (WIDTH=4, MODULUS=10).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
module tb_tcounter_param;
  import tcounter_pkg::*;

  localparam int unsigned Width   = 4;
  localparam int unsigned Modulus = 10;

  logic clk;
  logic clear_n;
  int   n_pass;
  int   n_total;

  tcounter_param_if #(.WIDTH(Width)) bus ();

  tcounter_param #(
    .WIDTH   (Width),
    .MODULUS (Modulus)
  ) dut (
    .clk     (clk),
    .clear_n (clear_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int qv, input int tcv, input int wv);
    check({tag, ".q"}, 32'(bus.q), qv);
    check({tag, ".tc"}, 32'(bus.tc), tcv);
    check({tag, ".wrap"}, 32'(bus.wrap), wv);
  endtask

  initial begin
    n_pass       = 0;
    n_total      = 0;
    clear_n      = 1'b0;
    bus.clear    = 1'b0;
    bus.en       = 1'b0;
    bus.up       = TC_DIR_UP;
    bus.load     = 1'b0;
    bus.load_val = '0;

    repeat (2) step();
    check_state("reset", 0, 0, 0);
    clear_n = 1'b1;

    // Async reset in the middle of counting.
    bus.load = 1'b1; bus.load_val = 4'd6;
    step();
    bus.load = 1'b0; bus.en = 1'b1; bus.up = TC_DIR_UP;
    check_state("load6", 6, 0, 0);
    step();
    check("count7.q", 32'(bus.q), 7);
    #2 clear_n = 1'b0;
    #1;
    check_state("async_clr", 0, 0, 0);
    #1 clear_n = 1'b1;
    step();
    check_state("post_rst", 1, 0, 0);

    // Up count across the wrap.
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check_state($sformatf("up%0d", i), i, (i == 9) ? 1 : 0, 0);
      step();
    end
    check_state("up_wrap", 0, 0, 1);
    bus.en = 1'b0;
    step();
    check_state("up_after", 0, 0, 0);

    // Down count across the wrap.
    bus.load = 1'b1; bus.load_val = 4'd2;
    step();
    bus.load = 1'b0; bus.en = 1'b1; bus.up = TC_DIR_DOWN;
    check_state("dn2", 2, 0, 0);
    step();
    check_state("dn1", 1, 0, 0);
    step();
    check_state("dn0", 0, 1, 0);
    step();
    check_state("dn_wrap", 9, 0, 1);
    bus.en = 1'b0;
    step();
    check_state("dn_after", 9, 0, 0);

    // Priority and clamping.
    bus.clear = 1'b1; bus.load = 1'b1; bus.load_val = 4'd5; bus.en = 1'b1;
    bus.up = TC_DIR_UP;
    step();
    check("prio_clr.q", 32'(bus.q), 0);
    bus.clear = 1'b0; bus.load_val = 4'd12;
    step();
    check_state("clamp12", 9, 1, 0);
    bus.load_val = 4'd10;  // q=9, en=1, up=1: load must suppress the wrap
    step();
    check_state("clamp10", 9, 1, 0);
    bus.load_val = 4'd3;
    step();
    check("load3.q", 32'(bus.q), 3);

    // Hold, then direction changes every edge.
    bus.load = 1'b1; bus.load_val = 4'd4; bus.en = 1'b0;
    step();
    bus.load = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("hold%0d", i), 4, 0, 0);
    end
    bus.en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.up = (i % 2 == 0) ? TC_DIR_UP : TC_DIR_DOWN;
      step();
      check($sformatf("dir%0d.q", i), 32'(bus.q), (i % 2 == 0) ? 5 : 4);
    end

`ifdef TCOUNTER_SAT_EN
    // Saturating ends.
    bus.load = 1'b1; bus.load_val = 4'd8; bus.en = 1'b0;
    step();
    bus.load = 1'b0; bus.en = 1'b1; bus.up = TC_DIR_UP;
    for (int i = 0; i < 3; i++) begin
      step();
      check_state($sformatf("sat_up%0d", i), 9, 1, 0);
    end
    bus.load = 1'b1; bus.load_val = 4'd1; bus.en = 1'b0;
    step();
    bus.load = 1'b0; bus.en = 1'b1; bus.up = TC_DIR_DOWN;
    for (int i = 0; i < 2; i++) begin
      step();
      check_state($sformatf("sat_dn%0d", i), 0, 1, 0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
